// File: rtl/fb_sched_pkg.sv
// -----------------------------------------------------------------------------
// fb_sched_pkg
// Shared types and constants for the framebuffer write scheduler.
//   FB_ADDR_W    : framebuffer address width (19 bits, covers up to 512K pixels)
//   FB_DATA_W    : pixel width (8 bpp)
//   FB_DEPTH_VGA : 640x480 pixel count, the default clear sweep length
//   fb_addr_t    : framebuffer address
//   fb_pixel_t   : framebuffer pixel
//   sched_state_t: scheduler FSM state (IDLE arbitrates, CLEAR sweeps)
// -----------------------------------------------------------------------------
package fb_sched_pkg;

    localparam int FB_ADDR_W    = 19;
    localparam int FB_DATA_W    = 8;
    localparam int FB_DEPTH_VGA = 307200;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;
    typedef logic [FB_DATA_W-1:0] fb_pixel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } sched_state_t;

endpackage : fb_sched_pkg

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Purely combinational round-robin picker: finds the first asserted request
// searching upward from ptr_i and wrapping modulo NUM_REQ.
// Ports:
//   req_i       : request vector
//   ptr_i       : index with highest priority this cycle (must be < NUM_REQ)
//   grant_o     : one-hot grant, zero when no request is asserted
//   grant_idx_o : binary index of the granted request (0 when none)
//   any_grant_o : high when some request is granted
// -----------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   grant_idx_o,
    output logic               any_grant_o
);

    // cand[k] is the requester examined at search position k (ptr + k mod N).
    logic [PTR_W-1:0] cand [NUM_REQ];
    logic [PTR_W:0]   cand_sum [NUM_REQ];
    logic [NUM_REQ-1:0] rot_req;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rotate
            assign cand_sum[gi] = {1'b0, ptr_i} + (PTR_W+1)'(gi);
            // The sum never reaches 2*NUM_REQ, so a single subtract wraps it.
            assign cand[gi] = (cand_sum[gi] >= (PTR_W+1)'(NUM_REQ))
                            ? PTR_W'(cand_sum[gi] - (PTR_W+1)'(NUM_REQ))
                            : cand_sum[gi][PTR_W-1:0];
            assign rot_req[gi] = req_i[cand[gi]];
        end
    endgenerate

    // Lowest search position wins: scan downward so the last hit is kept.
    always_comb begin
        any_grant_o = 1'b0;
        grant_idx_o = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                any_grant_o = 1'b1;
                grant_idx_o = cand[k];
            end
        end
        grant_o = '0;
        if (any_grant_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

endmodule : rr_priority_picker

// File: rtl/framebuffer_write_scheduler.sv
// -----------------------------------------------------------------------------
// framebuffer_write_scheduler
// Shares the single framebuffer write port between NUM_REQ requesters using
// round-robin arbitration, and provides a clear engine that fills the whole
// framebuffer (FB_DEPTH addresses) with one colour at one write per clock.
// Ports:
//   clock, reset               : application clock, synchronous active-high reset
//   req_valid/address/data     : packed per-requester write requests
//   req_ready                  : one-hot grant (combinational), transfer on valid&ready
//   clear_start, clear_color   : clear request pulse and its fill colour
//   clear_busy                 : high for exactly the FB_DEPTH clear write cycles
//   framebuffer_write_*        : registered write port towards the shell
// -----------------------------------------------------------------------------
module framebuffer_write_scheduler
    import fb_sched_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int FB_DEPTH = FB_DEPTH_VGA
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*FB_ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ*FB_DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           clear_start,
    input  logic [FB_DATA_W-1:0]           clear_color,
    output logic                           clear_busy,
    output logic                           framebuffer_write_clock,
    output logic                           framebuffer_write_signal,
    output logic [FB_ADDR_W-1:0]           framebuffer_write_address,
    output logic [FB_DATA_W-1:0]           framebuffer_write_data
);

    localparam int       PTR_W     = $clog2(NUM_REQ);
    localparam fb_addr_t LAST_ADDR = fb_addr_t'(FB_DEPTH - 1);

    sched_state_t     state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    fb_addr_t         clr_cnt_q, clr_cnt_d;
    fb_pixel_t        clr_color_q, clr_color_d;
    logic             wr_sig_q, wr_sig_d;
    fb_addr_t         wr_addr_q, wr_addr_d;
    fb_pixel_t        wr_data_q, wr_data_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;
    logic               arb_en;

    // Unpacked views of the flat request buses.
    fb_addr_t  req_addr_arr [NUM_REQ];
    fb_pixel_t req_data_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_addr_arr[gi] = req_address[gi*FB_ADDR_W +: FB_ADDR_W];
            assign req_data_arr[gi] = req_data[gi*FB_DATA_W +: FB_DATA_W];
        end
    endgenerate

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (pick_grant),
        .grant_idx_o (pick_idx),
        .any_grant_o (pick_any)
    );

    // Arbitration only in IDLE; a clear request in the same cycle wins, and
    // nothing is granted while reset is held so no transfer is lost to it.
    assign arb_en    = (state_q == IDLE) && !clear_start && !reset;
    assign req_ready = arb_en ? pick_grant : '0;

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clear_start) state_d = CLEAR;
            CLEAR:   if (clr_cnt_q == LAST_ADDR) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output / datapath logic ----------------
    // clr_cnt_q always holds the address currently shown on the write port
    // during a clear, so the sweep ends on the cycle address FB_DEPTH-1 is out.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        clr_cnt_d   = clr_cnt_q;
        clr_color_d = clr_color_q;
        wr_sig_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    // First clear write is issued straight from the accept cycle.
                    clr_color_d = clear_color;
                    clr_cnt_d   = '0;
                    wr_sig_d    = 1'b1;
                    wr_addr_d   = '0;
                    wr_data_d   = clear_color;
                end else if (pick_any) begin
                    wr_sig_d  = 1'b1;
                    wr_addr_d = req_addr_arr[pick_idx];
                    wr_data_d = req_data_arr[pick_idx];
                    rr_ptr_d  = (pick_idx == PTR_W'(NUM_REQ - 1))
                              ? '0 : pick_idx + PTR_W'(1);
                end
            end
            CLEAR: begin
                if (clr_cnt_q != LAST_ADDR) begin
                    clr_cnt_d = clr_cnt_q + fb_addr_t'(1);
                    wr_sig_d  = 1'b1;
                    wr_addr_d = clr_cnt_q + fb_addr_t'(1);
                    wr_data_d = clr_color_q;
                end
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            clr_cnt_q   <= '0;
            clr_color_q <= '0;
            wr_sig_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_color_q <= clr_color_d;
            wr_sig_q    <= wr_sig_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign clear_busy                = (state_q == CLEAR);
    assign framebuffer_write_clock   = clock;
    assign framebuffer_write_signal  = wr_sig_q;
    assign framebuffer_write_address = wr_addr_q;
    assign framebuffer_write_data    = wr_data_q;

endmodule : framebuffer_write_scheduler

// File: tb/tb_framebuffer_write_scheduler.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_write_scheduler
// Directed testbench: 3 requesters, 16-entry clear sweep.
// -----------------------------------------------------------------------------
module tb_framebuffer_write_scheduler;

    localparam int NR    = 3;
    localparam int DEPTH = 16;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*19-1:0]  req_address;
    logic [NR*8-1:0]   req_data;
    logic [NR-1:0]     req_ready;
    logic              clear_start;
    logic [7:0]        clear_color;
    logic              clear_busy;
    logic              fb_clk;
    logic              fb_sig;
    logic [18:0]       fb_addr;
    logic [7:0]        fb_data;

    int n_checks = 0;
    int n_fail   = 0;

    framebuffer_write_scheduler #(
        .NUM_REQ  (NR),
        .FB_DEPTH (DEPTH)
    ) dut (
        .clock                     (clk),
        .reset                     (reset),
        .req_valid                 (req_valid),
        .req_address               (req_address),
        .req_data                  (req_data),
        .req_ready                 (req_ready),
        .clear_start               (clear_start),
        .clear_color               (clear_color),
        .clear_busy                (clear_busy),
        .framebuffer_write_clock   (fb_clk),
        .framebuffer_write_signal  (fb_sig),
        .framebuffer_write_address (fb_addr),
        .framebuffer_write_data    (fb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input logic v, input logic [18:0] a, input logic [7:0] d);
        req_valid[i]          = v;
        req_address[i*19 +: 19] = a;
        req_data[i*8 +: 8]    = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_start = 1'b0;
        clear_color = 8'h00;
        set_req(0, 1'b1, 19'h00001, 8'h01);
        set_req(1, 1'b1, 19'h00002, 8'h02);
        set_req(2, 1'b1, 19'h00003, 8'h03);
        next_cycle();
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            n_checks++;
            if (fb_sig !== 1'b0 || req_ready !== 3'b000 || clear_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_cycle%0d: sig=%b ready=%b busy=%b, required 0 000 0", r, fb_sig, req_ready, clear_busy);
            end
            next_cycle();
        end
        reset = 1'b0;
        req_valid = '0;
        @(negedge clk);
        n_checks++;
        if (fb_sig !== 1'b0 || req_ready !== 3'b000 || clear_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after: sig=%b ready=%b busy=%b, required 0 000 0", fb_sig, req_ready, clear_busy);
        end
        $display("reset: done");
        next_cycle();
    endtask

    task automatic test_single();
        set_req(1, 1'b1, 19'h00123, 8'hA5);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 3'b010) begin
            n_fail++;
            $display("FAIL single_ready: got %b, required 010", req_ready);
        end
        next_cycle();
        req_valid = '0;
        n_checks++;
        if (fb_sig !== 1'b1 || fb_addr !== 19'h00123 || fb_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_write: sig=%b addr=%h data=%h, required 1 00123 a5", fb_sig, fb_addr, fb_data);
        end
        next_cycle();
        n_checks++;
        if (fb_sig !== 1'b0 || fb_addr !== 19'h00123) begin
            n_fail++;
            $display("FAIL single_once: sig=%b addr=%h, required 0 00123 (held)", fb_sig, fb_addr);
        end
        $display("single: write addr=%h data=%h", 19'h00123, 8'hA5);
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_ready;
        // Pointer is 2 after the single write; one grant to req2 returns it to 0.
        set_req(2, 1'b1, 19'h00055, 8'h22);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 3'b100) begin
            n_fail++;
            $display("FAIL rr_prep_ready: got %b, required 100", req_ready);
        end
        next_cycle();
        req_valid = '0;
        n_checks++;
        if (fb_sig !== 1'b1 || fb_addr !== 19'h00055 || fb_data !== 8'h22) begin
            n_fail++;
            $display("FAIL rr_prep_write: sig=%b addr=%h data=%h, required 1 00055 22", fb_sig, fb_addr, fb_data);
        end
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 19'h00100 + 19'(i), 8'h10 + 8'(i));
        for (int k = 0; k < 6; k++) begin
            exp_ready = 3'b001 << (k % 3);
            @(negedge clk);
            n_checks++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got %b, required %b", k, req_ready, exp_ready);
            end
            next_cycle();
            n_checks++;
            if (fb_sig !== 1'b1 || fb_addr !== 19'h00100 + 19'(k % 3) || fb_data !== 8'h10 + 8'(k % 3)) begin
                n_fail++;
                $display("FAIL rr_write%0d: sig=%b addr=%h data=%h, required 1 %h %h", k, fb_sig, fb_addr, fb_data,
                         19'h00100 + 19'(k % 3), 8'h10 + 8'(k % 3));
            end
            $display("rr: cycle %0d granted requester %0d", k, k % 3);
        end
        req_valid = '0;
    endtask

    task automatic test_clear();
        clear_start = 1'b1;
        clear_color = 8'h3C;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 3'b000 || clear_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_accept: ready=%b busy=%b, required 000 0", req_ready, clear_busy);
        end
        next_cycle();
        clear_start = 1'b0;
        clear_color = 8'hFF;
        set_req(1, 1'b1, 19'h00777, 8'h77);
        for (int c = 0; c < DEPTH; c++) begin
            n_checks++;
            if (fb_sig !== 1'b1 || fb_addr !== 19'(c) || fb_data !== 8'h3C || clear_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL clear_write%0d: sig=%b addr=%h data=%h busy=%b, required 1 %h 3c 1",
                         c, fb_sig, fb_addr, fb_data, clear_busy, 19'(c));
            end
            @(negedge clk);
            n_checks++;
            if (req_ready !== 3'b000) begin
                n_fail++;
                $display("FAIL clear_ready%0d: got %b, required 000", c, req_ready);
            end
            next_cycle();
        end
        n_checks++;
        if (fb_sig !== 1'b0 || clear_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_end: sig=%b busy=%b, required 0 0", fb_sig, clear_busy);
        end
        @(negedge clk);
        n_checks++;
        if (req_ready !== 3'b010) begin
            n_fail++;
            $display("FAIL clear_resume_ready: got %b, required 010", req_ready);
        end
        next_cycle();
        req_valid = '0;
        n_checks++;
        if (fb_sig !== 1'b1 || fb_addr !== 19'h00777 || fb_data !== 8'h77) begin
            n_fail++;
            $display("FAIL clear_resume_write: sig=%b addr=%h data=%h, required 1 00777 77", fb_sig, fb_addr, fb_data);
        end
        $display("clear: %0d writes of 3c swept", DEPTH);
    endtask

    task automatic test_collision();
        clear_start = 1'b1;
        clear_color = 8'h81;
        set_req(0, 1'b1, 19'h04000, 8'hC0);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL coll_ready: got %b, required 000", req_ready);
        end
        next_cycle();
        clear_start = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            n_checks++;
            if (fb_sig !== 1'b1 || fb_addr !== 19'(c) || fb_data !== 8'h81) begin
                n_fail++;
                $display("FAIL coll_clear%0d: sig=%b addr=%h data=%h, required 1 %h 81", c, fb_sig, fb_addr, fb_data, 19'(c));
            end
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if (req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL coll_after_ready: got %b, required 001", req_ready);
        end
        next_cycle();
        req_valid = '0;
        n_checks++;
        if (fb_sig !== 1'b1 || fb_addr !== 19'h04000 || fb_data !== 8'hC0) begin
            n_fail++;
            $display("FAIL coll_after_write: sig=%b addr=%h data=%h, required 1 04000 c0", fb_sig, fb_addr, fb_data);
        end
        $display("collision: clear first, then requester 0");
    endtask

    task automatic test_reset_mid_clear();
        clear_start = 1'b1;
        clear_color = 8'h5A;
        next_cycle();
        clear_start = 1'b0;
        for (int c = 0; c < 4; c++) next_cycle();
        n_checks++;
        if (fb_sig !== 1'b1 || fb_addr !== 19'h00004 || fb_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL midrst_5th: sig=%b addr=%h data=%h, required 1 00004 5a", fb_sig, fb_addr, fb_data);
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        n_checks++;
        if (fb_sig !== 1'b0 || clear_busy !== 1'b0 || fb_addr !== 19'h0) begin
            n_fail++;
            $display("FAIL midrst_abort: sig=%b busy=%b addr=%h, required 0 0 00000", fb_sig, clear_busy, fb_addr);
        end
        // Pointer was 1 before reset; reset returns it to 0.
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 19'h00200 + 19'(i), 8'h40 + 8'(i));
        @(negedge clk);
        n_checks++;
        if (req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL midrst_ptr: got %b, required 001", req_ready);
        end
        next_cycle();
        req_valid = '0;
        clear_start = 1'b1;
        clear_color = 8'h66;
        next_cycle();
        clear_start = 1'b0;
        n_checks++;
        if (fb_sig !== 1'b1 || fb_addr !== 19'h0 || fb_data !== 8'h66 || clear_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_restart: sig=%b addr=%h data=%h busy=%b, required 1 00000 66 1", fb_sig, fb_addr, fb_data, clear_busy);
        end
        for (int c = 1; c < DEPTH; c++) next_cycle();
        n_checks++;
        if (fb_addr !== 19'(DEPTH - 1) || clear_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_last: addr=%h busy=%b, required %h 1", fb_addr, clear_busy, 19'(DEPTH - 1));
        end
        next_cycle();
        n_checks++;
        if (fb_sig !== 1'b0 || clear_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_done: sig=%b busy=%b, required 0 0", fb_sig, clear_busy);
        end
        $display("reset_mid_clear: aborted at addr 4, restarted from 0");
    endtask

    initial begin
        req_valid   = '0;
        req_address = '0;
        req_data    = '0;
        reset       = 1'b1;
        clear_start = 1'b0;
        clear_color = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_clear();
        test_collision();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_framebuffer_write_scheduler
